// File: rtl/cp0_reg.sv
// ---------------------------------------------------------------------------
// cp0_reg -- Coprocessor-0 register file for the 5-stage MIPS core.
//
// Holds Count, Compare, Status, Cause, EPC, PRId and Config. The single write
// port comes from the memory/writeback pipeline register (already qualified
// by stall/flush). Exception events from the memory stage update
// Status/Cause/EPC with priority over a same-cycle software write. The
// read port serves mfc0 combinationally from the registered values.
//
// Optional feature macro: CP0_TIMER_EN
//   defined   : Count/Compare timer and timer_int_o are implemented.
//   undefined : Count/Compare read as 0, writes to them are ignored,
//               count_o/compare_o are 0 and timer_int_o is tied low.
//
// Ports
//   clk                  in   clock, rising edge
//   resetn               in   asynchronous active-low reset
//   we/waddr/wdata       in   CP0 write port (mtc0 at writeback)
//   raddr                in   CP0 read register number (mfc0)
//   int_i[5:0]           in   external hardware interrupt lines -> Cause.IP[7:2]
//   excepttype_i[31:0]   in   exception code from memory stage, 0 = none
//   current_inst_addr_i  in   PC of the excepting instruction
//   is_in_delayslot_i    in   excepting instruction sits in a delay slot
//   rdata[31:0]          out  read data for raddr (0 for unmapped)
//   count_o..prid_o      out  current register values
//   timer_int_o          out  timer interrupt pending
// ---------------------------------------------------------------------------
module cp0_reg #(
    parameter logic [31:0] PRID       = 32'h004c0102,
    parameter logic [31:0] CONFIG_RST = 32'h00008000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] rdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    // Register numbers
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] REG_CONFIG  = 5'd16;

    // Exception type encodings delivered by the memory stage
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [31:0] STATUS_RST = 32'h1000_0000;  // CU0 = 1

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q,  cause_d;
    logic [31:0] epc_q,    epc_d;

    logic        exc_take;   // recognised exception that records ExcCode
    logic        exc_eret;   // eret: clears EXL only
    logic [4:0]  exc_code;

    // -----------------------------------------------------------------------
    // Exception decode
    // -----------------------------------------------------------------------
    // NOTE: every signal driven in always_comb gets a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        exc_take = 1'b0;
        exc_eret = 1'b0;
        exc_code = 5'd0;
        case (excepttype_i)
            EXC_INT:  begin exc_take = 1'b1; exc_code = 5'd0;  end
            EXC_SYS:  begin exc_take = 1'b1; exc_code = 5'd8;  end
            EXC_RI:   begin exc_take = 1'b1; exc_code = 5'd10; end
            EXC_OV:   begin exc_take = 1'b1; exc_code = 5'd12; end
            EXC_TRAP: begin exc_take = 1'b1; exc_code = 5'd13; end
            EXC_ERET: exc_eret = 1'b1;
            default:  ;  // unknown nonzero codes are ignored
        endcase
    end

    // -----------------------------------------------------------------------
    // Status / Cause / EPC next state
    // -----------------------------------------------------------------------
    always_comb begin
        status_d        = status_q;
        cause_d         = cause_q;
        epc_d           = epc_q;
        // Hardware interrupt pending bits track the pins every cycle.
        cause_d[15:10]  = int_i;

        if (exc_take) begin
            // A nested exception (EXL already set) keeps the original EPC/BD
            // so the handler can still return to the first faulting point.
            if (!status_q[1]) begin
                epc_d       = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                : current_inst_addr_i;
                cause_d[31] = is_in_delayslot_i;
            end
            status_d[1]    = 1'b1;
            cause_d[6:2]   = exc_code;
        end else if (exc_eret) begin
            status_d[1]    = 1'b0;
        end else if (we) begin
            case (waddr)
                REG_STATUS: status_d = wdata;
                REG_CAUSE: begin
                    // Only IP[1:0] (software interrupts), WP and IV are writable.
                    cause_d[9:8]   = wdata[9:8];
                    cause_d[23:22] = wdata[23:22];
                end
                REG_EPC:    epc_d = wdata;
                default:    ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q <= STATUS_RST;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Count / Compare timer
    // -----------------------------------------------------------------------
`ifdef CP0_TIMER_EN
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_int_q, timer_int_d;

    always_comb begin
        count_d     = count_q + 32'd1;   // free-running, wraps naturally
        compare_d   = compare_q;
        timer_int_d = timer_int_q;

        if (count_q == compare_q && compare_q != 32'd0) begin
            timer_int_d = 1'b1;
        end
        if (we && waddr == REG_COUNT) begin
            count_d = wdata;
        end
        // A Compare write acknowledges the interrupt and beats a same-cycle match.
        if (we && waddr == REG_COMPARE) begin
            compare_d   = wdata;
            timer_int_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;
`else
    assign count_o     = 32'd0;
    assign compare_o   = 32'd0;
    assign timer_int_o = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs and mfc0 read port (registered values only, no write bypass)
    // -----------------------------------------------------------------------
    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;
    assign config_o = CONFIG_RST;   // Config is read-only here
    assign prid_o   = PRID;

    always_comb begin
        rdata = 32'd0;
        case (raddr)
            REG_COUNT:   rdata = count_o;
            REG_COMPARE: rdata = compare_o;
            REG_STATUS:  rdata = status_q;
            REG_CAUSE:   rdata = cause_q;
            REG_EPC:     rdata = epc_q;
            REG_PRID:    rdata = PRID;
            REG_CONFIG:  rdata = CONFIG_RST;
            default:     rdata = 32'd0;
        endcase
    end

endmodule
